// File: rtl/mips_multicycle_if.sv
// mips_multicycle_if -- instruction and data memory bus of the multicycle core.
//   master (core):   drives imem_req/imem_addr, dmem_req/dmem_we/dmem_addr/dmem_wdata;
//                    samples imem_ack/imem_rdata, dmem_ack/dmem_rdata.
//   slave  (memory): the mirror image.
// A request stays asserted with stable address/data until the matching ack.
interface mips_multicycle_if #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 13
);
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_ack;
   logic [15:0]       imem_rdata;
   logic              dmem_req;
   logic              dmem_we;
   logic [DATA_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [DATA_W-1:0] dmem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mips_multicycle.sv
// mips_multicycle -- 8-register, 16-bit-instruction multicycle MIPS-like core.
// FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, or HALT (terminal).
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   bus            memory bus (mips_multicycle_if.master)
//   current_instr  instruction register
//   retire         one-cycle pulse in the last cycle of each instruction
//   halted         high while in HALT
module mips_multicycle #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 13
) (
   input  logic               clk,
   input  logic               rst,
   mips_multicycle_if.master  bus,
   output logic [15:0]        current_instr,
   output logic               retire,
   output logic               halted
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   typedef enum logic [2:0] {
      OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_HALT
   } opcode_t;

   localparam logic [3:0] FN_ADD = 4'd0;
   localparam logic [3:0] FN_SUB = 4'd1;
   localparam logic [3:0] FN_AND = 4'd2;
   localparam logic [3:0] FN_OR  = 4'd3;
   localparam logic [3:0] FN_SLT = 4'd4;
   localparam logic [3:0] FN_JR  = 4'd8;

   state_t            state, state_nx;
   logic              run;
   logic [PC_W-1:0]   pc;
   logic [15:0]       ir;
   logic [DATA_W-1:0] a, b, alu_q, mdr;
   logic [DATA_W-1:0] regs [8];

   opcode_t           op;
   logic [2:0]        rs, rt, rd;
   logic [3:0]        funct;
   logic [DATA_W-1:0] imm_ext;
   logic [PC_W-1:0]   jaddr;
   logic              is_alu_r;
   logic [DATA_W-1:0] rs_val, rt_val, alu_res, wb_data;
   logic [2:0]        wb_idx;
   logic              fetch_req, data_req, fetch_ack, data_ack;

   assign op       = opcode_t'(ir[15:13]);
   assign rs       = ir[12:10];
   assign rt       = ir[9:7];
   assign rd       = ir[6:4];
   assign funct    = ir[3:0];
   assign imm_ext  = {{(DATA_W-7){ir[6]}}, ir[6:0]};
   assign jaddr    = ir[PC_W-1:0];
   assign is_alu_r = (funct <= FN_SLT);

   assign rs_val = (rs == 3'd0) ? '0 : regs[rs];
   assign rt_val = (rt == 3'd0) ? '0 : regs[rt];

   // run stays low for the first cycle out of reset so that no request is
   // visible while reset is asserted; fetch begins on the first edge after.
   assign fetch_req = (state == FETCH) && run;
   assign data_req  = (state == MEM);
   assign fetch_ack = fetch_req && bus.imem_ack;
   assign data_ack  = data_req && bus.dmem_ack;

   // Request outputs are derived from registers only, so they hold steady
   // while waiting for an ack and fall to zero as soon as reset clears them.
   assign bus.imem_req   = fetch_req;
   assign bus.imem_addr  = pc;
   assign bus.dmem_req   = data_req;
   assign bus.dmem_we    = data_req && (op == OP_SW);
   assign bus.dmem_addr  = a + imm_ext;
   assign bus.dmem_wdata = b;

   assign current_instr = ir;
   assign halted        = (state == HALT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FETCH;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      retire   = 1'b0;
      unique case (state)
         FETCH:  if (fetch_ack) state_nx = DECODE;
         DECODE: state_nx = EXEC;
         EXEC: begin
            unique case (op)
               OP_R: begin
                  if (is_alu_r) begin
                     state_nx = WB;
                  end else begin
                     state_nx = FETCH;
                     retire   = 1'b1;
                  end
               end
               OP_ADDI, OP_JAL: state_nx = WB;
               OP_LW, OP_SW:    state_nx = MEM;
               OP_BEQ, OP_J: begin
                  state_nx = FETCH;
                  retire   = 1'b1;
               end
               OP_HALT: begin
                  state_nx = HALT;
                  retire   = 1'b1;
               end
            endcase
         end
         MEM: begin
            if (data_ack) begin
               if (op == OP_SW) begin
                  state_nx = FETCH;
                  retire   = 1'b1;
               end else begin
                  state_nx = WB;
               end
            end
         end
         WB: begin
            state_nx = FETCH;
            retire   = 1'b1;
         end
         HALT:    state_nx = HALT;
         default: state_nx = FETCH;
      endcase
   end

   always_comb begin
      alu_res = a + b;
      unique case (op)
         OP_R: begin
            case (funct)
               FN_SUB:  alu_res = a - b;
               FN_AND:  alu_res = a & b;
               FN_OR:   alu_res = a | b;
               FN_SLT:  alu_res = DATA_W'($signed(a) < $signed(b));
               default: alu_res = a + b;
            endcase
         end
         OP_ADDI: alu_res = a + imm_ext;
         // pc already points past this instruction, i.e. PC+1.
         OP_JAL:  alu_res = DATA_W'(pc);
         default: alu_res = a + b;
      endcase
   end

   always_comb begin
      wb_idx  = rt;
      wb_data = alu_q;
      unique case (op)
         OP_R:    wb_idx = rd;
         OP_LW:   wb_data = mdr;
         OP_JAL:  wb_idx = 3'd7;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run   <= 1'b0;
         pc    <= '0;
         ir    <= '0;
         a     <= '0;
         b     <= '0;
         alu_q <= '0;
         mdr   <= '0;
         regs  <= '{default: '0};
      end else begin
         run <= 1'b1;
         case (state)
            FETCH: begin
               if (fetch_ack) begin
                  ir <= bus.imem_rdata;
                  pc <= pc + PC_W'(1);
               end
            end
            DECODE: begin
               a <= rs_val;
               b <= rt_val;
            end
            EXEC: begin
               alu_q <= alu_res;
               case (op)
                  OP_R:   if (funct == FN_JR) pc <= a[PC_W-1:0];
                  OP_BEQ: if (a == b) pc <= pc + imm_ext[PC_W-1:0];
                  OP_J, OP_JAL: pc <= jaddr;
                  default: ;
               endcase
            end
            MEM: if (data_ack && (op == OP_LW)) mdr <= bus.dmem_rdata;
            WB:  if (wb_idx != 3'd0) regs[wb_idx] <= wb_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle -- scoreboard bench for mips_multicycle.
// Stimulus queues instruction words (served in fetch order), expected fetch
// addresses, retire records and data-bus transactions; a memory model answers
// requests and a monitor pops and compares whenever the DUT presents output.
module tb_mips_multicycle;

   typedef struct {
      logic [15:0] instr;
      int          cyc;
   } rexp_t;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          hold;
   } dexp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] current_instr;
   logic        retire;
   logic        halted;
   logic        ack_noise = 1'b0;

   logic [12:0] fq[$];
   logic [15:0] sq[$];
   rexp_t       rq[$];
   dexp_t       dq[$];
   int          dly_q[$];
   logic [15:0] rdq[$];
   int          hq[$];
   int          rstq[$];

   int n_vec = 0;
   int n_bad = 0;
   int cyc;

   mips_multicycle_if #(.DATA_W(16), .PC_W(13)) bus ();

   mips_multicycle #(.DATA_W(16), .PC_W(13)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.master),
      .current_instr (current_instr),
      .retire        (retire),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // ---------------- memory model ----------------
   int dcnt = 0;
   int dly  = 0;
   always @(negedge clk) begin
      if (!rst) begin
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = '0;
         bus.dmem_ack   = 1'b0;
         bus.dmem_rdata = '0;
         dcnt           = 0;
      end else begin
         if (ack_noise) begin
            bus.imem_ack = ~bus.imem_ack;
         end else if (bus.imem_req) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 16'h0000;
            if (sq.size() > 0) bus.imem_rdata = sq.pop_front();
         end else begin
            bus.imem_ack = 1'b0;
         end
         if (bus.dmem_req) begin
            if (dcnt == 0) begin
               dly = 0;
               if (dly_q.size() > 0) dly = dly_q.pop_front();
            end
            dcnt++;
            if (dcnt > dly) begin
               bus.dmem_ack   = 1'b1;
               bus.dmem_rdata = 16'h0000;
               if (rdq.size() > 0) bus.dmem_rdata = rdq.pop_front();
               dcnt = 0;
            end else begin
               bus.dmem_ack = 1'b0;
            end
         end else begin
            bus.dmem_ack = 1'b0;
            dcnt         = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pending();
      return fq.size() + rq.size() + dq.size() + hq.size();
   endfunction

   int          hold = 0;
   int          idle = 0;
   logic        chg  = 1'b0;
   logic [32:0] cap  = '0;

   always @(negedge clk) begin
      logic  progress;
      rexp_t r;
      dexp_t d;
      #1;
      progress = 1'b0;
      if (!rst) begin
         hold = 0;
         chg  = 1'b0;
         idle = 0;
         if (rstq.size() > 0) begin
            void'(rstq.pop_front());
            check("reset_ctrl", {27'd0, bus.imem_req, bus.dmem_req, bus.dmem_we, retire, halted}, 32'd0);
            check("reset_data", {31'd0, |{bus.imem_addr, bus.dmem_addr, bus.dmem_wdata, current_instr}}, 32'd0);
         end
      end else begin
         if (bus.imem_req && bus.imem_ack) begin
            check("fetch_pending", {31'd0, fq.size() > 0}, 32'd1);
            if (fq.size() > 0) begin
               check("fetch_addr", {19'd0, bus.imem_addr}, {19'd0, fq.pop_front()});
               progress = 1'b1;
            end
         end
         if (bus.dmem_req) begin
            if (hold == 0) cap = {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata};
            else if (cap !== {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}) chg = 1'b1;
            hold++;
            if (bus.dmem_ack) begin
               check("dmem_pending", {31'd0, dq.size() > 0}, 32'd1);
               if (dq.size() > 0) begin
                  d = dq.pop_front();
                  check("dmem_we",     {31'd0, bus.dmem_we},    {31'd0, d.we});
                  check("dmem_addr",   {16'd0, bus.dmem_addr},  {16'd0, d.addr});
                  check("dmem_wdata",  {16'd0, bus.dmem_wdata}, {16'd0, d.wdata});
                  check("dmem_hold",   hold,                    d.hold);
                  check("dmem_stable", {31'd0, chg},            32'd0);
                  progress = 1'b1;
               end
               hold = 0;
               chg  = 1'b0;
            end
         end else begin
            hold = 0;
            chg  = 1'b0;
         end
         if (retire) begin
            check("retire_pending", {31'd0, rq.size() > 0}, 32'd1);
            if (rq.size() > 0) begin
               r = rq.pop_front();
               check("retire_instr", {16'd0, current_instr}, {16'd0, r.instr});
               if (r.cyc >= 0) check("retire_cycle", cyc, r.cyc);
               progress = 1'b1;
            end
         end
         if (halted && hq.size() > 0) begin
            void'(hq.pop_front());
            check("halt_quiet", {29'd0, halted, bus.imem_req, bus.dmem_req}, 32'd4);
            progress = 1'b1;
         end
         if (pending() > 0 && !progress) idle++;
         else idle = 0;
         if (idle > 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL watchdog: %0d expectations left after 200 idle cycles", pending());
            fq.delete(); sq.delete(); rq.delete(); dq.delete();
            dly_q.delete(); rdq.delete(); hq.delete();
            idle = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [15:0] ri(input int rs, input int rt, input int rd, input int fn);
      return {3'b000, 3'(rs), 3'(rt), 3'(rd), 4'(fn)};
   endfunction

   function automatic logic [15:0] ii(input int op, input int rs, input int rt, input int imm);
      return {3'(op), 3'(rs), 3'(rt), 7'(imm)};
   endfunction

   function automatic logic [15:0] jj(input int op, input int addr);
      return {3'(op), 13'(addr)};
   endfunction

   task automatic f(input int addr, input logic [15:0] ins, input int c);
      rexp_t r;
      r.instr = ins;
      r.cyc   = c;
      fq.push_back(13'(addr));
      sq.push_back(ins);
      rq.push_back(r);
   endtask

   task automatic dx(input logic we, input int addr, input int wdata, input int rdata, input int delay);
      dexp_t d;
      d.we    = we;
      d.addr  = 16'(addr);
      d.wdata = 16'(wdata);
      d.hold  = delay + 1;
      dq.push_back(d);
      dly_q.push_back(delay);
      rdq.push_back(16'(rdata));
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #2;
      rst       = 1'b0;
      ack_noise = 1'b0;
      rstq.push_back(1);
      fq.delete(); sq.delete(); rq.delete(); dq.delete();
      dly_q.delete(); rdq.delete(); hq.delete();
      @(negedge clk);
      #2;
   endtask

   task automatic release_dut();
      @(negedge clk);
      #2;
      rst = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && pending() > 0; i++) @(negedge clk);
   endtask

   initial begin
      // Phase A: ALU, store with delayed ack, load, retire timing.
      reset_dut();
      f(0,  ii(1, 0, 1, 5),  4);     // addi R1,R0,5
      f(1,  ii(1, 0, 2, -3), 8);     // addi R2,R0,-3
      f(2,  ri(1, 2, 3, 0),  12);    // add  R3,R1,R2 -> 2
      f(3,  ii(3, 0, 3, 2),  19);    // sw   R3,2(R0), ack after 3 waits
      dx(1'b1, 2, 2, 0, 3);
      f(4,  ii(2, 0, 4, 2),  24);    // lw   R4,2(R0)
      dx(1'b0, 2, 0, 2, 0);
      f(5,  ii(3, 0, 4, 3),  -1);    // sw   R4,3(R0) -> 2
      dx(1'b1, 3, 2, 0, 0);
      f(6,  ri(1, 2, 5, 1),  -1);    // sub  R5 = 5-(-3) = 8
      f(7,  ii(3, 0, 5, 4),  -1);
      dx(1'b1, 4, 8, 0, 0);
      f(8,  ri(2, 1, 6, 4),  -1);    // slt  R6 = (-3 < 5) = 1
      f(9,  ii(3, 0, 6, 5),  -1);
      dx(1'b1, 5, 1, 0, 0);
      f(10, ri(1, 2, 6, 3),  -1);    // or   R6 = 5 | 0xFFFD = 0xFFFD
      f(11, ii(3, 0, 6, 6),  -1);
      dx(1'b1, 6, 16'hFFFD, 0, 0);
      f(12, ri(1, 2, 6, 2),  -1);    // and  R6 = 5 & 0xFFFD = 5
      f(13, ii(3, 0, 6, 7),  -1);
      dx(1'b1, 7, 5, 0, 0);
      f(14, ri(1, 2, 6, 4),  -1);    // slt  R6 = (5 < -3) = 0
      f(15, ii(3, 0, 6, 8),  -1);
      dx(1'b1, 8, 0, 0, 0);
      f(16, 16'hE000,        -1);    // halt
      release_dut();
      drain();

      // Phase B: j, beq taken onto itself, beq not taken, NOP funct, jr.
      reset_dut();
      f(0, ii(1, 0, 1, 1),  4);      // addi R1,R0,1
      f(1, ii(1, 0, 2, 2),  8);      // addi R2,R0,2
      f(2, jj(5, 5),        11);     // j 5
      f(5, ii(4, 1, 1, -1), 14);     // beq R1,R1,-1 -> 5
      f(5, ii(4, 1, 2, -1), 17);     // beq R1,R2,-1 not taken -> 6
      f(6, ri(0, 0, 0, 5),  20);     // undefined funct: NOP
      f(7, ii(1, 0, 3, 20), 24);     // addi R3,R0,20
      f(8, ri(3, 0, 0, 8),  27);     // jr R3 -> 20
      f(20, 16'hE000,       30);     // halt
      release_dut();
      drain();

      // Phase C: jal wrapping PC, writes to R0 discarded.
      reset_dut();
      f(0,       ii(1, 0, 7, 9), 4);   // addi R7,R0,9
      f(1,       ii(3, 0, 7, 3), 8);   // sw R7,3(R0) -> 9
      dx(1'b1, 3, 9, 0, 0);
      f(2,       jj(5, 13'h1FFF), 11); // j 0x1FFF
      f(13'h1FFF, jj(6, 13'h1FFF), 15);// jal 0x1FFF: R7 = 0x2000 mod 2^13 = 0
      f(13'h1FFF, ii(1, 0, 0, 7), 19); // addi R0,R0,7, PC wraps to 0
      f(0,       ii(3, 0, 7, 1), 23);  // sw R7,1(R0) -> 0
      dx(1'b1, 1, 0, 0, 0);
      f(1,       ii(3, 0, 0, 2), 27);  // sw R0,2(R0) -> 0
      dx(1'b1, 2, 0, 0, 0);
      f(2,       16'hE000,       30);
      release_dut();
      drain();

      // Phase D: reset while a store is pending, then halt with ack noise.
      reset_dut();
      f(0, ii(1, 0, 1, 3), 4);         // addi R1,R0,3
      f(1, ii(3, 0, 1, 0), -1);        // sw R1,0(R0), never acked
      dx(1'b1, 0, 3, 0, 50);
      release_dut();
      for (int i = 0; i < 100 && !bus.dmem_req; i++) @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset_dut();                     // abandons the store
      f(0, ii(3, 0, 1, 0), 4);         // sw R1,0(R0) -> 0 after reset
      dx(1'b1, 0, 0, 0, 0);
      f(1, 16'hE000, 7);
      release_dut();
      for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
      ack_noise = 1'b1;
      for (int i = 0; i < 20; i++) hq.push_back(i);
      drain();

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
